year_disp_scan: RTL and testbench



---
 rtl/year_disp_scan.sv | 138 +++++++++++++
 tb/tb_year_disp_scan.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/year_disp_scan.sv
// Multiplexed 4-digit 7-segment year display (common-anode, active-low) with per-frame
// digit snapshot, edit blink and anti-ghost blanking. Define YEAR_DISP_LZB_EN for leading-zero blanking.
module year_disp_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter logic [3:0]  PREFIX_DIGIT = 4'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] year_ones,
  input  logic [3:0] year_tens,
  input  logic [3:0] year_hundreds,
  input  logic       edit_en,
  input  logic [1:0] edit_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       sh_ones_q, sh_ones_d;
  logic [3:0]       sh_tens_q, sh_tens_d;
  logic [3:0]       sh_hund_q, sh_hund_d;
  logic             load_pending_q, load_pending_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic       tick, wrap, load, tick_next, lz_blank, blink_blank;
  logic [3:0] cur_val;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    tick      = (div_cnt_q == DIV_MAX);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    wrap      = tick && (idx_q == 2'd3);
    load      = load_pending_q || wrap;
    frame_start = load && !rst;
    load_pending_d = 1'b0;

    sh_ones_d = load ? year_ones     : sh_ones_q;
    sh_tens_d = load ? year_tens     : sh_tens_q;
    sh_hund_d = load ? year_hundreds : sh_hund_q;

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!edit_en) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Outputs are registered from next-state values so an/seg line up with idx/div_cnt.
    case (idx_d)
      2'd0:    cur_val = sh_ones_d;
      2'd1:    cur_val = sh_tens_d;
      2'd2:    cur_val = sh_hund_d;
      default: cur_val = PREFIX_DIGIT;
    endcase

    lz_blank = 1'b0;
`ifdef YEAR_DISP_LZB_EN
    if (PREFIX_DIGIT == 4'd0) begin
      case (idx_d)
        2'd3:    lz_blank = 1'b1;
        2'd2:    lz_blank = (sh_hund_d == 4'd0);
        2'd1:    lz_blank = (sh_hund_d == 4'd0) && (sh_tens_d == 4'd0);
        default: lz_blank = 1'b0;
      endcase
    end
`endif

    blink_blank = edit_en && blink_phase_d && (edit_sel != 2'd3) && (idx_d == edit_sel);
    tick_next   = (div_cnt_d == DIV_MAX);

    an_d  = tick_next ? '1 : ~(4'b0001 << idx_d);
    seg_d = (lz_blank || blink_blank) ? '1 : seg_decode(cur_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q      <= '0;
      idx_q          <= '0;
      sh_ones_q      <= '0;
      sh_tens_q      <= '0;
      sh_hund_q      <= '0;
      load_pending_q <= 1'b1;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      an_q           <= '1;
      seg_q          <= '1;
    end else begin
      div_cnt_q      <= div_cnt_d;
      idx_q          <= idx_d;
      sh_ones_q      <= sh_ones_d;
      sh_tens_q      <= sh_tens_d;
      sh_hund_q      <= sh_hund_d;
      load_pending_q <= load_pending_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_year_disp_scan.sv
// Directed table-driven bench for year_disp_scan (SCAN_DIV=4, BLINK_FRAMES=2) with two
// instances: prefix 2 and prefix 0 (the latter exercises leading-zero blanking when enabled).
module tb_year_disp_scan;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010, D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000, D9 = 7'b0010000, DASH = 7'b0111111, BL = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] yo, yt, yh;
  logic       ee;
  logic [1:0] es;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       fs0, fs1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  year_disp_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .PREFIX_DIGIT(4'd2)) dut0 (
    .clk(clk), .rst(rst), .year_ones(yo), .year_tens(yt), .year_hundreds(yh),
    .edit_en(ee), .edit_sel(es), .an(an0), .seg(seg0), .frame_start(fs0));

  year_disp_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .PREFIX_DIGIT(4'd0)) dut1 (
    .clk(clk), .rst(rst), .year_ones(yo), .year_tens(yt), .year_hundreds(yh),
    .edit_en(ee), .edit_sel(es), .an(an1), .seg(seg1), .frame_start(fs1));

  typedef struct {
    logic [3:0]      o, t, h;
    int              dsel;
    logic [6:0]      e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, t, h, input logic e, input logic [1:0] s);
    @(posedge clk);
    #1;
    yo = o; yt = t; yh = h; ee = e; es = s;
  endtask

  task automatic sync_frame();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (fs0) found = 1'b1;
    end
    chk("sync_timeout", found, 1);
  endtask

  // Samples cycles start_j..15 of a frame (cycle j has div_cnt = j%4, slot = j/4).
  task automatic capture(input string name, input int dsel, input logic [6:0] e0, e1, e2, e3,
                         input int start_j, input int chg_at, input logic [3:0] no, nt, nh);
    logic [6:0] exp_seg [4];
    logic [3:0] a, ea;
    logic [6:0] s;
    logic       f;
    exp_seg = '{e0, e1, e2, e3};
    for (int j = start_j; j < 16; j++) begin
      @(negedge clk);
      a = (dsel != 0) ? an1 : an0;
      s = (dsel != 0) ? seg1 : seg0;
      f = (dsel != 0) ? fs1 : fs0;
      if (j % 4 == 3) begin
        chk($sformatf("%s_an_off_c%0d", name, j), a, 4'hF);
      end else begin
        ea = ~(4'b0001 << (j / 4));
        chk($sformatf("%s_an_c%0d", name, j), a, ea);
        chk($sformatf("%s_seg_c%0d", name, j), s, exp_seg[j / 4]);
      end
      chk($sformatf("%s_fs_c%0d", name, j), f, (j == 15) ? 1 : 0);
      if (j == chg_at) begin
        yo = no; yt = nt; yh = nh;
      end
    end
  endtask

  task automatic do_reset(input string name, input logic [3:0] o, t, h, input logic [6:0] e0, e1, e2);
    @(posedge clk);
    #1;
    rst = 1'b1; yo = o; yt = t; yh = h; ee = 1'b0; es = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s_rst_an%0d", name, i), an0, 4'hF);
      chk($sformatf("%s_rst_seg%0d", name, i), seg0, 7'h7F);
      chk($sformatf("%s_rst_fs%0d", name, i), fs0, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk({name, "_c0_fs"}, fs0, 1);
    chk({name, "_c0_an"}, an0, 4'hF);
    chk({name, "_c0_seg"}, seg0, 7'h7F);
    capture(name, 0, e0, e1, e2, D2, 1, -1, 4'd0, 4'd0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; yo = '0; yt = '0; yh = '0; ee = 1'b0; es = 2'd3;

    vecs[0] = '{o: 4'd4, t: 4'd3,  h: 4'd0,  dsel: 0, e0: D4, e1: D3,   e2: D0,   e3: D2};
    vecs[1] = '{o: 4'd9, t: 4'd12, h: 4'd9,  dsel: 0, e0: D9, e1: DASH, e2: D9,   e3: D2};
    vecs[2] = '{o: 4'd8, t: 4'd6,  h: 4'd5,  dsel: 0, e0: D8, e1: D6,   e2: D5,   e3: D2};
    vecs[3] = '{o: 4'd1, t: 4'd7,  h: 4'd15, dsel: 0, e0: D1, e1: D7,   e2: DASH, e3: D2};
`ifdef YEAR_DISP_LZB_EN
    vecs[4] = '{o: 4'd5, t: 4'd0,  h: 4'd0,  dsel: 1, e0: D5, e1: BL,   e2: BL,   e3: BL};
    vecs[5] = '{o: 4'd0, t: 4'd3,  h: 4'd0,  dsel: 1, e0: D0, e1: D3,   e2: BL,   e3: BL};
    vecs[6] = '{o: 4'd0, t: 4'd0,  h: 4'd7,  dsel: 1, e0: D0, e1: D0,   e2: D7,   e3: BL};
`else
    vecs[4] = '{o: 4'd5, t: 4'd0,  h: 4'd0,  dsel: 1, e0: D5, e1: D0,   e2: D0,   e3: D0};
    vecs[5] = '{o: 4'd0, t: 4'd3,  h: 4'd0,  dsel: 1, e0: D0, e1: D3,   e2: D0,   e3: D0};
    vecs[6] = '{o: 4'd0, t: 4'd0,  h: 4'd7,  dsel: 1, e0: D0, e1: D0,   e2: D7,   e3: D0};
`endif

    do_reset("reset", 4'd7, 4'd4, 4'd0, D7, D4, D0);

    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].o, vecs[v].t, vecs[v].h, 1'b0, 2'd3);
      sync_frame();
      capture($sformatf("vec%0d", v), vecs[v].dsel, vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3,
              0, -1, 4'd0, 4'd0, 4'd0);
    end

    // Inputs change mid-frame while idx=1; the frame keeps the old snapshot.
    drive(4'd9, 4'd9, 4'd1, 1'b0, 2'd3);
    sync_frame();
    capture("coh_old", 0, D9, D9, D1, D2, 0, 5, 4'd0, 4'd0, 4'd2);
    capture("coh_new", 0, D0, D0, D2, D2, 0, -1, 4'd0, 4'd0, 4'd0);

    // Blink on tens: two visible frames, two blanked frames, then visible again.
    drive(4'd6, 4'd1, 4'd3, 1'b0, 2'd1);
    sync_frame();
    @(posedge clk);
    #1;
    ee = 1'b1;
    capture("blink_f1", 0, D6, D1, D3, D2, 0, -1, 4'd0, 4'd0, 4'd0);
    capture("blink_f2", 0, D6, D1, D3, D2, 0, -1, 4'd0, 4'd0, 4'd0);
    capture("blink_f3", 0, D6, BL, D3, D2, 0, -1, 4'd0, 4'd0, 4'd0);
    capture("blink_f4", 0, D6, BL, D3, D2, 0, -1, 4'd0, 4'd0, 4'd0);
    capture("blink_f5", 0, D6, D1, D3, D2, 0, -1, 4'd0, 4'd0, 4'd0);
    es = 2'd3;
    capture("nosel_f6", 0, D6, D1, D3, D2, 0, -1, 4'd0, 4'd0, 4'd0);
    capture("nosel_f7", 0, D6, D1, D3, D2, 0, -1, 4'd0, 4'd0, 4'd0);
    capture("nosel_f8", 0, D6, D1, D3, D2, 0, -1, 4'd0, 4'd0, 4'd0);

    // Reset asserted mid-frame restarts the scan at idx 0.
    repeat (6) @(posedge clk);
    do_reset("midrst", 4'd3, 4'd8, 4'd1, D3, D8, D1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
